// File: rtl/out_shift_ctrl.sv
// out_shift_ctrl: sequences clear/load/run/drain of out_reg_shift and realigns its valid strobe
module out_shift_ctrl #(
  parameter int I_WIDTH       = 8,
  parameter int F_WIDTH       = 8,
  parameter int N             = 3,
  parameter int NUM_COL_WIDTH = $clog2(N + 1),
  parameter int ROW_WIDTH     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [NUM_COL_WIDTH-1:0] cfg_num_cols_i,
  input  logic [ROW_WIDTH-1:0]     cfg_num_rows_i,
  output logic                     cfg_err_o,
  input  logic                     src_valid_i,
  output logic                     src_ready_o,
  output logic                     shift_rst_o,
  output logic                     cols_rst_o,
  output logic                     cols_ld_o,
  output logic [NUM_COL_WIDTH-1:0] cols_o,
  output logic                     out_valid_o,
  output logic                     busy_o,
  output logic                     done_o
);
  if (N < 2 || I_WIDTH < 1 || F_WIDTH < 0) begin : g_bad_param
    $error("out_shift_ctrl: illegal parameters");
  end
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DRAIN, DONE} state_t;
  state_t                   r_state, w_next;
  logic [NUM_COL_WIDTH-1:0] r_cols, r_cols_o, w_d;
  logic [ROW_WIDTH-1:0]     r_rows, r_in_cnt, r_out_cnt;
  logic [N-2:0]             r_vline;
  logic [N-1:0]             w_vnext;
  logic                     r_err, r_shift_rst, r_cols_ld;
  logic                     w_hs, w_illegal, w_accept, w_ov, w_clr;
  assign w_hs      = cfg_valid_i & (r_state == IDLE);
  assign w_illegal = (cfg_num_cols_i == '0) || (cfg_num_cols_i > NUM_COL_WIDTH'(N));
  assign w_accept  = src_valid_i & (r_state == RUN);
  assign w_d       = NUM_COL_WIDTH'(N) - r_cols;
  assign w_vnext   = {r_vline, w_accept};
  assign w_clr     = (w_next == CLEAR);
  // a sample accepted now leaves the shifter D cycles later; D = 0 is a pass-through
  always_comb begin
    w_ov = (w_d == '0) & w_accept;
    for (int i = 0; i < N - 1; i++) if (w_d == NUM_COL_WIDTH'(i + 1)) w_ov = r_vline[i];
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_hs ? CLEAR : IDLE;
      CLEAR:   w_next = LOAD;
      LOAD:    w_next = (r_rows == '0) ? DRAIN : RUN;
      RUN:     w_next = (w_accept && r_in_cnt == r_rows - ROW_WIDTH'(1)) ? DRAIN : RUN;
      DRAIN:   w_next = (r_out_cnt == r_rows) ? DONE : DRAIN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_cols      <= '0;
      r_rows      <= '0;
      r_err       <= 1'b0;
      r_cols_o    <= '0;
      r_cols_ld   <= 1'b0;
      r_shift_rst <= 1'b1;
      r_vline     <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
    end else begin
      r_state     <= w_next;
      r_shift_rst <= w_clr;
      r_cols_ld   <= (w_next == LOAD);
      r_vline     <= w_clr ? '0 : w_vnext[N-2:0];
      r_in_cnt    <= w_clr ? '0 : r_in_cnt + ROW_WIDTH'(w_accept);
      r_out_cnt   <= w_clr ? '0 : r_out_cnt + ROW_WIDTH'(w_ov);
      if (w_hs) begin
        r_cols <= w_illegal ? NUM_COL_WIDTH'(N) : cfg_num_cols_i;
        r_rows <= cfg_num_rows_i;
        r_err  <= w_illegal;
      end
      if (w_next == LOAD) r_cols_o <= r_cols;
    end
  end
  assign cfg_ready_o = (r_state == IDLE);
  assign cfg_err_o   = (r_state == CLEAR) & r_err;
  assign src_ready_o = (r_state == RUN);
  assign shift_rst_o = r_shift_rst;
  assign cols_rst_o  = r_shift_rst;
  assign cols_ld_o   = r_cols_ld;
  assign cols_o      = r_cols_o;
  assign out_valid_o = w_ov;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
endmodule

// File: tb/tb_out_shift_ctrl.sv
// tb_out_shift_ctrl: timeline model of tile phases and valid delays, checked every cycle
module tb_out_shift_ctrl;
  localparam int N = 3, CW = $clog2(N + 1), RW = 8, MAXC = 2048;
  logic clk = 1'b0, rst_n = 1'b1, cfg_valid = 1'b0, src_valid = 1'b0;
  logic [CW-1:0] cfg_cols = '0;
  logic [RW-1:0] cfg_rows = '0;
  logic cfg_ready, cfg_err, src_ready, shift_rst, cols_rst, cols_ld, out_valid, busy, done;
  logic [CW-1:0] cols;
  always #5 clk = ~clk;
  out_shift_ctrl #(.N(N), .ROW_WIDTH(RW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_num_cols_i(cfg_cols), .cfg_num_rows_i(cfg_rows), .cfg_err_o(cfg_err),
    .src_valid_i(src_valid), .src_ready_o(src_ready), .shift_rst_o(shift_rst),
    .cols_rst_o(cols_rst), .cols_ld_o(cols_ld), .cols_o(cols), .out_valid_o(out_valid),
    .busy_o(busy), .done_o(done));
  int n_tests = 0, n_fail = 0, cyc = 0;
  // model: a tile is a handshake cycle plus a schedule of expected events
  bit tile_on = 0, post_rst = 0, t_err = 0, m_act, m_sr, m_acc;
  int hs = -100, done_cyc = 32'h3fffffff, t_rows = 0, t_cols = 0, t_d = 0, n_acc = 0, exp_cols = 0, last_hs = -1;
  bit ov_at [MAXC+16];
  bit obs_ov [MAXC], obs_done [MAXC], obs_err [MAXC], obs_ld [MAXC], obs_busy [MAXC];
  int obs_cols [MAXC];
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      obs_ov[cyc] = out_valid; obs_done[cyc] = done; obs_err[cyc] = cfg_err;
      obs_ld[cyc] = cols_ld; obs_busy[cyc] = busy; obs_cols[cyc] = int'(cols);
    end
    if (!rst_n) begin
      tile_on = 0; post_rst = 1; exp_cols = 0;
      for (int i = 0; i <= N; i++) ov_at[cyc+i] = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_shift_rst", shift_rst, 1);
      chk("rst_cols_rst", cols_rst, 1);
      chk("rst_cols_ld", cols_ld, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_cols", cols, 0);
      chk("rst_src_ready", src_ready, 0);
    end else begin
      m_act = tile_on && cyc > hs && cyc <= done_cyc;
      m_sr  = m_act && cyc >= hs + 3 && n_acc < t_rows;
      m_acc = m_sr && src_valid;
      if (m_acc) begin
        ov_at[cyc+t_d] = 1;
        n_acc++;
        if (n_acc == t_rows) done_cyc = cyc + t_d + 2;
      end
      if (m_act && cyc == hs + 2) exp_cols = t_cols;
      chk("busy", busy, m_act);
      chk("cfg_ready", cfg_ready, !m_act);
      chk("src_ready", src_ready, m_sr);
      chk("shift_rst", shift_rst, (m_act && cyc == hs + 1) || post_rst);
      chk("cols_rst", cols_rst, (m_act && cyc == hs + 1) || post_rst);
      chk("cols_ld", cols_ld, m_act && cyc == hs + 2);
      chk("cols", cols, exp_cols);
      chk("cfg_err", cfg_err, m_act && cyc == hs + 1 && t_err);
      chk("out_valid", out_valid, ov_at[cyc]);
      chk("done", done, m_act && cyc == done_cyc);
      post_rst = 0;
      if (!m_act && cfg_valid) begin
        tile_on = 1; hs = cyc; last_hs = cyc; n_acc = 0;
        t_rows = int'(cfg_rows);
        t_err = (cfg_cols == 0) || (int'(cfg_cols) > N);
        t_cols = t_err ? N : int'(cfg_cols);
        t_d = N - t_cols;
        done_cyc = (t_rows == 0) ? cyc + 4 : 32'h3fffffff;
      end
    end
  end
  task automatic do_cfg(input int c, input int r);
    bit ok = 0;
    cfg_cols = CW'(c); cfg_rows = RW'(r); cfg_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = cfg_ready; end
    @(posedge clk); #1 cfg_valid = 0;
    chk("cfg_handshake", ok, 1);
  endtask
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = done; end
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
  endtask
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, k2, s;
    logic [3:0] pat;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step(1);
    // full width, continuous source: out_valid coincides with accepts
    src_valid = 1; do_cfg(3, 4); k = last_hs; wait_done(); src_valid = 0;
    chk("t1_ov_window", {obs_ov[k+3], obs_ov[k+4], obs_ov[k+5], obs_ov[k+6], obs_ov[k+7]}, 5'b11110);
    chk("t1_done_at", obs_done[k+8], 1);
    // D = 2 with a bubble
    do_cfg(1, 3); k = last_hs; step(2);
    pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin src_valid = pat[3-i]; step(1); end
    src_valid = 0; wait_done();
    chk("t2_ov_lead", {obs_ov[k+3], obs_ov[k+4]}, 0);
    chk("t2_ov_pattern", {obs_ov[k+5], obs_ov[k+6], obs_ov[k+7], obs_ov[k+8]}, 4'b1011);
    chk("t2_done_at", obs_done[k+10], 1);
    // illegal column count clamps to N
    src_valid = 1; do_cfg(0, 2); k = last_hs; wait_done(); src_valid = 0;
    chk("t3_err_in_clear", obs_err[k+1], 1);
    chk("t3_ld_in_load", obs_ld[k+2], 1);
    chk("t3_cols_clamped", obs_cols[k+2], 3);
    chk("t3_ov_d0", {obs_ov[k+3], obs_ov[k+4]}, 2'b11);
    chk("t3_done_at", obs_done[k+6], 1);
    // empty tile
    do_cfg(2, 0); k = last_hs; wait_done();
    s = 0;
    for (int i = 0; i <= 5; i++) s += obs_ov[k+i];
    chk("t4_no_ov", s, 0);
    chk("t4_done_at", obs_done[k+4], 1);
    chk("t4_idle_after", obs_busy[k+5], 0);
    // cfg held during a tile is ignored until IDLE
    src_valid = 1; do_cfg(3, 3); k = last_hs;
    cfg_cols = 1; cfg_rows = 1; cfg_valid = 1;
    wait_done(); step(1); cfg_valid = 0; k2 = last_hs;
    chk("t5_second_hs", k2, k + 8);
    chk("t5_cols_held", obs_cols[k+6], 3);
    wait_done(); src_valid = 0;
    chk("t5_second_cols", obs_cols[k2+2], 1);
    chk("t5_second_ov", {obs_ov[k2+4], obs_ov[k2+5]}, 2'b01);
    chk("t5_second_done", obs_done[k2+7], 1);
    // reset during DRAIN drops the tile
    src_valid = 1; do_cfg(1, 2); k = last_hs; step(4);
    rst_n = 0; step(1); rst_n = 1; src_valid = 0; step(8);
    s = 0;
    for (int i = 5; i <= 12; i++) s += obs_done[k+i];
    chk("t6_no_done", s, 0);
    chk("t6_busy_in_rst", obs_busy[k+5], 0);
    chk("t6_ov_killed", obs_ov[k+5], 0);
    src_valid = 1; do_cfg(2, 2); k2 = last_hs; wait_done(); src_valid = 0;
    chk("t6_clean_ov", {obs_ov[k2+3], obs_ov[k2+4], obs_ov[k2+5], obs_ov[k2+6]}, 4'b0110);
    chk("t6_clean_done", obs_done[k2+7], 1);
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/out_shift_ctrl.md
# out_shift_ctrl

Sequencing controller for the `out_reg_shift` output alignment register. It accepts a per-tile configuration (active column count, sample count) and clears and loads the shifter. It then gates the source stream into it and regenerates a `valid` strobe aligned to the shifter's variable delay of N − cols cycles. It sits between the systolic array output and the writeback stage and signals tile completion. It is control-only: data flows source → shifter directly, not through this block.

## Interface
- `I_WIDTH`, 8, integer bits of the shifter data (kept for shifter parameter consistency).
- `F_WIDTH`, 8, fractional bits of the shifter data (kept for shifter parameter consistency).
- `N`, 3, shifter depth (maximum columns), ≥ 2.
- `NUM_COL_WIDTH`, $clog2(N+1), width of column count; must represent N.
- `ROW_WIDTH`, 8, width of sample counters; maximum rows is 2^ROW_WIDTH − 1.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `cfg_valid_i`  in  1  configuration request.
- `cfg_ready_o`  out  1  high only in IDLE; handshake = valid & ready.
- `cfg_num_cols_i`  in  NUM_COL_WIDTH  active columns, legal 1..N.
- `cfg_num_rows_i`  in  ROW_WIDTH  samples in this tile, 0 allowed.
- `cfg_err_o`  out  1  one-cycle pulse: illegal column count was clamped.
- `src_valid_i`  in  1  source sample present on shifter `in_data_i`.
- `src_ready_o`  out  1  high only in RUN.
- `shift_rst_o`  out  1  registered, active-high, drives shifter `out_reg_shift_rst_i`.
- `cols_rst_o`  out  1  registered, active-high, drives shifter `number_of_columns_rst_i`.
- `cols_ld_o`  out  1  registered, drives shifter `number_of_columns_ld_i`.
- `cols_o`  out  NUM_COL_WIDTH  registered, drives shifter `number_of_columns_i`.
- `out_valid_o`  out  1  shifter `out_data_o` carries a valid sample this cycle.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  high for exactly one cycle (DONE state).

## Operation
- **States:** IDLE → CLEAR → LOAD → RUN → DRAIN → DONE → IDLE. Each of CLEAR, LOAD and DONE lasts one cycle.
- **IDLE:**
  - On a cfg handshake, latch cols and rows, then go to CLEAR.
  - `cfg_valid_i` in any other state is ignored; `cfg_ready_o` is 0 in those states.
- **Column legalisation:** cols = 0 or cols > N is latched as N, and `cfg_err_o` pulses in the CLEAR cycle.
- **CLEAR:**
  - `shift_rst_o` = 1 and `cols_rst_o` = 1.
  - Valid delay line and both counters cleared.
- **LOAD:** `cols_ld_o` = 1 and `cols_o` = latched cols.
  - `cols_o` holds that value until the next configuration.
- **RUN:**
  - `src_ready_o` = 1; accept = `src_valid_i` & `src_ready_o`.
  - in_cnt increments on each accept.
  - On the accept where in_cnt == rows − 1, go to DRAIN.
  - If rows == 0, LOAD goes directly to DRAIN.
- **Delay tracking:**
  - D = N − cols, in the range 0..N−1.
  - vline is N−1 bits: vline[0] ← accept, vline[i] ← vline[i−1]. It shifts every cycle, matching the shifter, which has no enable.
  - `out_valid_o` = accept when D = 0; otherwise vline[D−1].
  - Source bubbles propagate as invalid slots.
- **Output count:** out_cnt increments on each `out_valid_o`.
- **DRAIN:** `src_ready_o` = 0; go to DONE when the registered out_cnt == rows.
- **DONE:** `done_o` = 1, then go to IDLE.
- **Reset:** asynchronous on `rst_n_i` low, from any state.
  - State = IDLE.
  - Counters, vline and `cols_o` = 0.
  - `cols_ld_o`, `cfg_err_o`, `out_valid_o`, `done_o` and `busy_o` = 0.
  - `shift_rst_o` = 1 and `cols_rst_o` = 1, so the shifter is held cleared during reset. Both deassert on the first clock after `rst_n_i` rises.
  - A reset mid-RUN or mid-DRAIN discards the tile with no `done_o`.

## Timing
- Handshake at edge k: CLEAR in cycle k+1, LOAD in k+2, first RUN cycle (`src_ready_o` = 1) in k+3.
- The shifter sees its column value loaded on the edge ending LOAD, so the first RUN cycle is already aligned.
- Sample accepted in cycle t: `out_valid_o` in cycle t+D, coincident with that sample on shifter `out_data_o`.
- Last `out_valid_o` in cycle L: DONE in cycle L+2, IDLE in L+3. The next cfg can be accepted in L+3.
- rows = 0: DRAIN in k+3, DONE in k+4.
- `out_valid_o` is combinational only when D = 0, where it passes through from `src_valid_i`; otherwise it is registered.

## Test plan
- **Full width, no gaps:** N=3, cols=3, rows=4, `src_valid_i` = 1 continuously. Expect `out_valid_o` in the same 4 cycles as the accepts, `src_ready_o` low after the 4th accept, and `done_o` 2 cycles after the last valid.
- **Delayed, with bubbles:** cols=1 (D=2), rows=3, valid pattern 1,0,1,1. Expect `out_valid_o` pattern 1,0,1,1 starting 2 cycles after the first accept, data matching the source, and exactly one `done_o`.
- **Illegal columns:** cfg cols=0, rows=2. Expect `cfg_err_o` pulse in CLEAR, `cols_o` = 3, `cols_ld_o` pulse in LOAD, and D = 0 behaviour.
- **Empty tile:** rows=0. Expect CLEAR, LOAD, DRAIN, DONE with `src_ready_o` never high, no `out_valid_o`, and `done_o` at k+4.
- **Busy ignores cfg:** `cfg_valid_i` held high during RUN with new cols. Expect `cfg_ready_o` = 0 and `cols_o` unchanged until IDLE, then the second cfg accepted in the first IDLE cycle.
- **Reset mid-run:** `rst_n_i` low for 1 cycle during DRAIN. Expect IDLE immediately, `shift_rst_o`/`cols_rst_o` = 1 while low, `busy_o` = 0, no `done_o`, and a clean next tile.
